// File: rtl/vector_sweep_capture_if.sv
// Stimulus/response bundle between the sweep controller and its environment.
interface vector_sweep_capture_if #(
  parameter int unsigned N_WIDTH = 6
) ();

  localparam int unsigned NVEC = 1 << N_WIDTH;

  logic                 start;
  logic                 abort;
  logic                 dut_out;
  logic [N_WIDTH-1:0]   N_out;
  logic                 busy;
  logic                 done;
  logic [NVEC-1:0]      resp_vec;
  logic [N_WIDTH:0]     ones_count;
  logic [15:0]          signature;

  // Environment side: requests sweeps and returns the DUT response.
  modport master (
    output start, abort, dut_out,
    input  N_out, busy, done, resp_vec, ones_count, signature
  );

  // Controller side.
  modport slave (
    input  start, abort, dut_out,
    output N_out, busy, done, resp_vec, ones_count, signature
  );

endinterface

// File: rtl/vector_sweep_capture.sv
// Exhaustive stimulus sweep: drives every N_WIDTH-bit vector, waits for the
// DUT to settle, captures its one-bit response and folds it into a MISR.
module vector_sweep_capture #(
  parameter int unsigned N_WIDTH       = 6,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                   CK,
  input logic                   reset,
  vector_sweep_capture_if.slave bus
);

  localparam int unsigned NVEC     = 1 << N_WIDTH;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ONES_W   = N_WIDTH + 1;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;
  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [N_WIDTH-1:0] LAST_IDX    = N_WIDTH'(NVEC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_e;

  state_e              state_q,      state_d;
  logic [N_WIDTH-1:0]  index_q,      index_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [N_WIDTH-1:0]  n_out_q,      n_out_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic [NVEC-1:0]     resp_vec_q,   resp_vec_d;
  logic [ONES_W-1:0]   ones_count_q, ones_count_d;
  logic [15:0]         signature_q,  signature_d;
  logic                fb;

  // State and result registers; reset forces the idle/seeded values at once.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      settle_cnt_q <= '0;
      n_out_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_vec_q   <= '0;
      ones_count_q <= '0;
      signature_q  <= SIG_SEED;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      settle_cnt_q <= settle_cnt_d;
      n_out_q      <= n_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_vec_q   <= resp_vec_d;
      ones_count_q <= ones_count_d;
      signature_q  <= signature_d;
    end
  end

  // Next-state logic; N_out is loaded on entry to APPLY so it is valid in APPLY.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    settle_cnt_d = settle_cnt_q;
    n_out_d      = n_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resp_vec_d   = resp_vec_q;
    ones_count_d = ones_count_q;
    signature_d  = signature_q;
    fb           = signature_q[15] ^ bus.dut_out;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          index_d      = '0;
          n_out_d      = '0;
          resp_vec_d   = '0;
          ones_count_d = '0;
          signature_d  = SIG_SEED;
          busy_d       = 1'b1;
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        resp_vec_d[index_q] = bus.dut_out;
        ones_count_d        = ones_count_q + ONES_W'(bus.dut_out);
        signature_d         = {signature_q[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
        if (index_q == LAST_IDX) begin
          n_out_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          index_d = index_q + N_WIDTH'(1);
          n_out_d = index_q + N_WIDTH'(1);
          state_d = S_APPLY;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides the active-sweep transitions and discards this sample.
    if (bus.abort && (state_q == S_APPLY || state_q == S_SETTLE ||
                      state_q == S_SAMPLE)) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      n_out_d      = '0;
      index_d      = index_q;
      settle_cnt_d = settle_cnt_q;
      resp_vec_d   = resp_vec_q;
      ones_count_d = ones_count_q;
      signature_d  = signature_q;
    end
  end

  // Output drive from registered state.
  assign bus.N_out      = n_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.resp_vec   = resp_vec_q;
  assign bus.ones_count = ones_count_q;
  assign bus.signature  = signature_q;

endmodule

// File: tb/tb_vector_sweep_capture.sv
// Scoreboard bench for vector_sweep_capture: two instances (settle 1 and 4).
module tb_vector_sweep_capture;

  typedef struct {
    logic [63:0] resp;
    int          ones;
    logic [15:0] sig;
    int          lat;
  } exp_t;

  logic CK = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mode0 = 0;
  int   acc0 = 0, acc1 = 0;
  logic busy0_prev = 1'b0, busy1_prev = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  vector_sweep_capture_if #(.N_WIDTH(6)) bus0 ();
  vector_sweep_capture_if #(.N_WIDTH(6)) bus1 ();

  vector_sweep_capture #(.N_WIDTH(6), .SETTLE_CYCLES(1)) u_dut0 (
    .CK(CK), .reset(reset), .bus(bus0)
  );
  vector_sweep_capture #(.N_WIDTH(6), .SETTLE_CYCLES(4)) u_dut1 (
    .CK(CK), .reset(reset), .bus(bus1)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Combinational stand-ins for the device under test.
  always_comb begin
    case (mode0)
      1:       bus0.dut_out = bus0.N_out[0];
      2:       bus0.dut_out = &bus0.N_out;
      3:       bus0.dut_out = bus0.N_out[5];
      default: bus0.dut_out = 1'b0;
    endcase
  end
  always_comb bus1.dut_out = bus1.N_out[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] misr(input logic [63:0] r, input int n);
    logic [15:0] s;
    logic        f;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      f = s[15] ^ r[i];
      s = {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  function automatic logic [63:0] exp_resp(input int m);
    case (m)
      1:       return 64'hAAAA_AAAA_AAAA_AAAA;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_0000_0000;
      default: return 64'h0;
    endcase
  endfunction

  function automatic int exp_ones(input int m);
    case (m)
      1:       return 32;
      2:       return 1;
      3:       return 32;
      default: return 0;
    endcase
  endfunction

  // Monitor for instance 0: latency from accept, results at the done pulse.
  always @(negedge CK) begin
    exp_t e;
    if (bus0.busy && !busy0_prev) acc0 = cyc;
    busy0_prev = bus0.busy;
    if (bus0.done) begin
      if (q0.size() == 0) begin
        chk("unexpected_done0", 64'(1), 64'(0));
      end else begin
        e = q0.pop_front();
        chk("done0_resp", bus0.resp_vec, e.resp);
        chk("done0_ones", 64'(bus0.ones_count), 64'(e.ones));
        chk("done0_sig", 64'(bus0.signature), 64'(e.sig));
        chk("done0_lat", 64'(cyc - acc0), 64'(e.lat));
        chk("done0_busy", 64'(bus0.busy), 64'(0));
        chk("done0_nout", 64'(bus0.N_out), 64'(0));
      end
    end
  end

  // Monitor for instance 1 (settle 4).
  always @(negedge CK) begin
    exp_t e;
    if (bus1.busy && !busy1_prev) acc1 = cyc;
    busy1_prev = bus1.busy;
    if (bus1.done) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 64'(1), 64'(0));
      end else begin
        e = q1.pop_front();
        chk("done1_resp", bus1.resp_vec, e.resp);
        chk("done1_ones", 64'(bus1.ones_count), 64'(e.ones));
        chk("done1_sig", 64'(bus1.signature), 64'(e.sig));
        chk("done1_lat", 64'(cyc - acc1), 64'(e.lat));
      end
    end
  end

  // Full sweep on instance 0 with N_out sequence checking; optional ignored start.
  task automatic run_sweep0(input int m, input int repulse_at);
    exp_t e;
    int   nbad;
    mode0  = m;
    e.resp = exp_resp(m);
    e.ones = exp_ones(m);
    e.sig  = misr(e.resp, 64);
    e.lat  = 192;
    q0.push_back(e);
    bus0.start = 1'b1;
    @(negedge CK);
    bus0.start = 1'b0;
    chk("start_accept", 64'(bus0.busy), 64'(1));
    nbad = 0;
    for (int c = 0; c < 192; c++) begin
      bus0.start = (c == repulse_at) ? 1'b1 : 1'b0;
      if (bus0.N_out !== 6'(c / 3) || bus0.busy !== 1'b1) nbad++;
      @(negedge CK);
    end
    bus0.start = 1'b0;
    chk("nout_sequence", 64'(nbad), 64'(0));
  endtask

  task automatic wait_nout0(input int v);
    int t;
    t = 0;
    while (bus0.N_out !== 6'(v) && t < 300) begin
      @(negedge CK);
      t++;
    end
    chk("reach_vector", 64'(bus0.N_out), 64'(v));
  endtask

  initial begin
    int t;
    reset      = 1'b0;
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    repeat (3) @(negedge CK);

    chk("rst_busy", 64'(bus0.busy), 64'(0));
    chk("rst_done", 64'(bus0.done), 64'(0));
    chk("rst_nout", 64'(bus0.N_out), 64'(0));
    chk("rst_resp", bus0.resp_vec, 64'(0));
    chk("rst_ones", 64'(bus0.ones_count), 64'(0));
    chk("rst_sig", 64'(bus0.signature), 64'hFFFF);

    // Release reset and request a sweep for the very first edge.
    reset = 1'b1;
    run_sweep0(0, -1);
    repeat (5) @(negedge CK);
    chk("idle_hold_sig0", 64'(bus0.signature), 64'(misr(64'h0, 64)));
    chk("idle_nout", 64'(bus0.N_out), 64'(0));

    run_sweep0(1, -1);
    repeat (5) @(negedge CK);
    chk("idle_hold_resp1", bus0.resp_vec, 64'hAAAA_AAAA_AAAA_AAAA);

    // Abort while vector 20 is applied.
    mode0 = 1;
    bus0.start = 1'b1;
    @(negedge CK);
    bus0.start = 1'b0;
    wait_nout0(20);
    bus0.abort = 1'b1;
    @(negedge CK);
    bus0.abort = 1'b0;
    chk("abort_busy", 64'(bus0.busy), 64'(0));
    chk("abort_nout", 64'(bus0.N_out), 64'(0));
    chk("abort_resp_lo", 64'(bus0.resp_vec[19:0]), 64'hAAAAA);
    chk("abort_resp_hi", 64'(bus0.resp_vec[63:20]), 64'(0));
    chk("abort_ones", 64'(bus0.ones_count), 64'(10));
    chk("abort_sig", 64'(bus0.signature), 64'(misr(64'hAAAA_AAAA_AAAA_AAAA, 20)));
    repeat (4) @(negedge CK);
    chk("abort_hold_ones", 64'(bus0.ones_count), 64'(10));

    // Abort and start together in IDLE: nothing starts.
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    @(negedge CK);
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    chk("abort_wins_busy", 64'(bus0.busy), 64'(0));
    chk("abort_wins_ones", 64'(bus0.ones_count), 64'(10));

    // Restart after abort from vector 0.
    run_sweep0(2, -1);
    repeat (3) @(negedge CK);

    // Asynchronous reset in SETTLE of vector 40.
    mode0 = 1;
    bus0.start = 1'b1;
    @(negedge CK);
    bus0.start = 1'b0;
    wait_nout0(40);
    @(negedge CK);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus0.busy), 64'(0));
    chk("async_rst_nout", 64'(bus0.N_out), 64'(0));
    chk("async_rst_resp", bus0.resp_vec, 64'(0));
    chk("async_rst_ones", 64'(bus0.ones_count), 64'(0));
    chk("async_rst_sig", 64'(bus0.signature), 64'hFFFF);
    chk("async_rst_done", 64'(bus0.done), 64'(0));
    @(negedge CK);
    reset = 1'b1;

    // Sweep with a second start mid-way that must be ignored.
    run_sweep0(1, 10);
    repeat (3) @(negedge CK);

    // Settle-4 instance, MSB response.
    begin
      exp_t e;
      e.resp = exp_resp(3);
      e.ones = exp_ones(3);
      e.sig  = misr(e.resp, 64);
      e.lat  = 384;
      q1.push_back(e);
    end
    bus1.start = 1'b1;
    @(negedge CK);
    bus1.start = 1'b0;
    t = 0;
    while (q1.size() != 0 && t < 600) begin
      @(negedge CK);
      t++;
    end
    chk("dut1_done_seen", 64'(q1.size()), 64'(0));
    chk("dut0_queue_empty", 64'(q0.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
